multiword_adder_seq_amisha: RTL and testbench
=============================================

MULTIWORD_ADDER_SEQ_AMISHA -- requirements
Module: multiword_adder_seq_amisha

Interface
REQ-001 SHALL have parameter N, default 4: chunk width in bits added per cycle; N >= 1.
REQ-002 SHALL have parameter K, default 4: number of chunks; K >= 2; operand width W = N*K.
REQ-003 SHALL have port clk_amisha, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n_amisha, input, 1: asynchronous reset, active-low.
REQ-005 SHALL have port start_amisha, input, 1: request a new operation; sampled only when ready_amisha=1.
REQ-006 SHALL have port sub_amisha, input, 1: 0 = A+B, 1 = A-B; sampled with start.
REQ-007 SHALL have port a_amisha, input, W: operand A; sampled with start.
REQ-008 SHALL have port b_amisha, input, W: operand B; sampled with start.
REQ-009 SHALL have port ready_amisha, output, 1: high when idle and able to accept start.
REQ-010 SHALL have port done_amisha, output, 1: one-cycle pulse marking a valid result.
REQ-011 SHALL have port sum_amisha, output, W: result, modulo 2^W.
REQ-012 SHALL have port cout_amisha, output, 1: unsigned carry out of bit W-1 (for subtract: 1 = no borrow).
REQ-013 SHALL have port ovf_amisha, output, 1: two's-complement signed overflow of the W-bit operation.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: ready_amisha=1; start_amisha=1 -> latch A, B xor {W{sub}}, carry register = sub, chunk index = 0, go RUN.
REQ-016 RUN: each cycle add chunk i of A, chunk i of latched B, and carry register (N+1-bit result); store low N bits into result chunk i, bit N into carry register; increment index.
REQ-017 RUN SHALL last exactly K cycles, processing chunks LSB first; after chunk K-1 go DONE.
REQ-018 DONE: drive done_amisha=1 for exactly one cycle; update sum_amisha, cout_amisha, ovf_amisha from completed internal result; return to IDLE next cycle.
REQ-019 Latency: start accepted at edge t -> done_amisha high in cycle after edge t+K+1; throughput one operation per K+2 cycles.
REQ-020 ready_amisha SHALL be 0 in RUN and DONE; start_amisha in those states SHALL be ignored and not queued.
REQ-021 Operand inputs changing after acceptance SHALL NOT affect the in-flight result.
REQ-022 ovf_amisha = carry into bit W-1 xor carry out of bit W-1 of the final chunk.
REQ-023 sum_amisha, cout_amisha, ovf_amisha SHALL hold last completed result unchanged through IDLE and subsequent RUN until next DONE.
REQ-024 Chunk index SHALL be wide enough for K (clog2), never wrap during an operation.

Reset
REQ-025 reset_n_amisha=0 SHALL immediately (asynchronously) force IDLE, ready_amisha=1, done_amisha=0, sum_amisha=0, cout_amisha=0, ovf_amisha=0, carry register and index = 0.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse; first start after reset release is accepted normally.
REQ-027 start_amisha high on the first edge after reset release SHALL be accepted.

Verification (N=4, K=4, W=16)
REQ-028 A=0xFFFF, B=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0, done pulse exactly 5 cycles after accepting edge, width 1 cycle.
REQ-029 A=0x7FFF, B=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-030 A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-031 Start held high continuously with changing operands -> only operands at accepting edges used; no start accepted while ready=0; back-to-back results every 6 cycles.
REQ-032 Reset asserted mid-RUN (2 chunks done) -> outputs 0 immediately, no done pulse; new A=0x1234, B=0x4321 add -> sum=0x5555, cout=0.
REQ-033 After DONE, change A/B without start -> sum/cout/ovf remain at last result for 20 cycles.

Source files
------------

// File: rtl/multiword_adder_seq_amisha.sv
// multiword_adder_seq_amisha: sequential W-bit add/subtract, one N-bit chunk per cycle, LSB first.
module multiword_adder_seq_amisha #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic           clk_amisha,
    input  logic           reset_n_amisha,
    input  logic           start_amisha,
    input  logic           sub_amisha,
    input  logic [N*K-1:0] a_amisha,
    input  logic [N*K-1:0] b_amisha,
    output logic           ready_amisha,
    output logic           done_amisha,
    output logic [N*K-1:0] sum_amisha,
    output logic           cout_amisha,
    output logic           ovf_amisha
);
    localparam int W = N * K;
    localparam int IW = $clog2(K);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [W-1:0] a_r, b_r, res_r;
    logic carry, msb_c;
    logic [IW-1:0] idx;
    logic [N:0] s;
    assign s = {1'b0, a_r[N-1:0]} + {1'b0, b_r[N-1:0]} + {{N{1'b0}}, carry};
    // operands shift down so the active chunk is always at the bottom; result fills from the top
    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            state <= IDLE;
            a_r <= '0;
            b_r <= '0;
            res_r <= '0;
            carry <= 1'b0;
            msb_c <= 1'b0;
            idx <= '0;
            ready_amisha <= 1'b1;
            done_amisha <= 1'b0;
            sum_amisha <= '0;
            cout_amisha <= 1'b0;
            ovf_amisha <= 1'b0;
        end else begin
            done_amisha <= 1'b0;
            case (state)
                IDLE: if (start_amisha) begin
                    a_r <= a_amisha;
                    b_r <= b_amisha ^ {W{sub_amisha}};
                    carry <= sub_amisha;
                    idx <= '0;
                    ready_amisha <= 1'b0;
                    state <= RUN;
                end
                RUN: begin
                    a_r <= a_r >> N;
                    b_r <= b_r >> N;
                    res_r <= {s[N-1:0], res_r[W-1:N]};
                    carry <= s[N];
                    msb_c <= a_r[N-1] ^ b_r[N-1] ^ s[N-1];
                    idx <= idx + 1'b1;
                    if (idx == IW'(K - 1)) state <= DONE;
                end
                DONE: begin
                    sum_amisha <= res_r;
                    cout_amisha <= carry;
                    ovf_amisha <= carry ^ msb_c;
                    done_amisha <= 1'b1;
                    ready_amisha <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_adder_seq_amisha.sv
// tb_multiword_adder_seq_amisha: scoreboard bench with directed vectors for the sequential adder.
module tb_multiword_adder_seq_amisha;
    localparam int N = 4;
    localparam int K = 4;
    localparam int W = N * K;
    logic clk = 0, rst_n = 0, start = 0, sub = 0;
    logic [W-1:0] a = '0, b = '0;
    logic ready, done, cout, ovf;
    logic [W-1:0] sum;
    typedef struct {logic [W-1:0] s; logic c; logic o; int acc;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, failures = 0, cyc = 0;
    logic done_d = 0;
    logic [W-1:0] bb_a [3] = '{16'h1000, 16'hF000, 16'h4000};
    logic [W-1:0] bb_b [3] = '{16'h0234, 16'h2000, 16'h4000};
    logic [W-1:0] bb_s [3] = '{16'h1234, 16'h1000, 16'h8000};
    logic bb_c [3] = '{1'b0, 1'b1, 1'b0};
    logic bb_o [3] = '{1'b0, 1'b0, 1'b1};

    multiword_adder_seq_amisha #(.N(N), .K(K)) dut (
        .clk_amisha(clk), .reset_n_amisha(rst_n), .start_amisha(start), .sub_amisha(sub),
        .a_amisha(a), .b_amisha(b), .ready_amisha(ready), .done_amisha(done),
        .sum_amisha(sum), .cout_amisha(cout), .ovf_amisha(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_expected", 32'(q.size() > 0), 1);
            chk("done_width", done_d, 0);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("cout", cout, e.c);
                chk("ovf", ovf, e.o);
                chk("latency", cyc, e.acc + 5);
            end
        end
        done_d <= done;
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", ready, 1);
    endtask

    task automatic issue(input logic [W-1:0] ia, ib, input logic isub,
                         input logic [W-1:0] es, input logic ec, eo);
        wait_ready();
        a = ia; b = ib; sub = isub; start = 1;
        q.push_back('{es, ec, eo, cyc + 1});
        @(negedge clk);
        start = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1;
        issue(16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
        issue(16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
        issue(16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0);
        issue(16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1);
        drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            chk("hold_sum", sum, 16'h7FFF);
            chk("hold_cout", cout, 1);
            chk("hold_ovf", ovf, 1);
        end
        wait_ready();
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            start = 1;
            if (i % 6 == 0) begin
                a = bb_a[i/6]; b = bb_b[i/6]; sub = 0;
                q.push_back('{bb_s[i/6], bb_c[i/6], bb_o[i/6], cyc + 1});
                chk("b2b_ready", ready, 1);
            end else begin
                a = 16'hAAAA ^ W'(i); b = 16'h5555; sub = 1'(i);
                chk("b2b_busy", ready, 0);
            end
        end
        @(negedge clk);
        start = 0;
        drain();
        issue(16'h0F0F, 16'h0101, 0, 16'h1010, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", ready, 1);
        q.delete();
        @(negedge clk);
        rst_n = 1;
        a = 16'h1234; b = 16'h4321; sub = 0; start = 1;
        q.push_back('{16'h5555, 1'b0, 1'b0, cyc + 1});
        @(negedge clk);
        start = 0;
        drain();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
